// File: rtl/subpel_abc_filter_simple_pkg.sv
// Shared types, coefficient tables and shift-add helpers for the 8-tap A/B/C sub-pel filter.
// Outputs are sums scaled by 64; consumers take bits [37:6].
package subpel_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SUM_W  = 40;
    localparam int unsigned NTAPS  = 8;

    typedef logic [DATA_W-1:0]        sample_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef sample_t [NTAPS-1:0]      window_t;

    typedef enum logic [1:0] {
        COEF_SET_A,
        COEF_SET_B,
        COEF_SET_C
    } coef_set_e;

    // Tap k applies to window slot 7-k; every set sums to 64.
    localparam int COEF_A [NTAPS] = '{0, 4, -8, 56, 16, -4, 0, 0};
    localparam int COEF_B [NTAPS] = '{0, 4, -8, 36, 36, -8, 4, 0};
    localparam int COEF_C [NTAPS] = '{0, 0, -4, 16, 56, -8, 4, 0};

    function automatic int coefOf(coef_set_e coefSet, logic [2:0] tap);
        int coef;
        coef = 0;
        case (coefSet)
            COEF_SET_A: coef = COEF_A[tap];
            COEF_SET_B: coef = COEF_B[tap];
            COEF_SET_C: coef = COEF_C[tap];
            default:    coef = 0;
        endcase
        return coef;
    endfunction

    // Only the coefficient values present in the tables are decomposed.
    function automatic sum_t shiftAddMul(sum_t x, int coef);
        sum_t product;
        product = '0;
        case (coef)
            0:       product = '0;
            4:       product = x <<< 2;
            -4:      product = -(x <<< 2);
            -8:      product = -(x <<< 3);
            16:      product = x <<< 4;
            36:      product = (x <<< 5) + (x <<< 2);
            56:      product = (x <<< 6) - (x <<< 3);
            default: product = '0;
        endcase
        return product;
    endfunction

    function automatic sum_t zeroExtend(sample_t sample);
        return sum_t'({{(SUM_W-DATA_W){1'b0}}, sample});
    endfunction

endpackage

// File: rtl/subpel_abc_filter_simple_if.sv
// Sample-in / sum-out bundle of the sub-pel filter.
interface subpel_abc_filter_simple_if;
    import subpel_pkg::*;

    logic    shift_en;
    sample_t data_in;
    sum_t    a_value;
    sum_t    b_value;
    sum_t    c_value;

    modport master (
        output shift_en,
        output data_in,
        input  a_value,
        input  b_value,
        input  c_value
    );

    modport slave (
        input  shift_en,
        input  data_in,
        output a_value,
        output b_value,
        output c_value
    );

endinterface

// File: rtl/subpel_abc_filter_simple_fir8.sv
// Combinational 8-tap FIR over a sample window using constant shift-add products.
module subpel_fir8_shiftadd
    import subpel_pkg::*;
#(
    parameter coef_set_e COEF_SET = COEF_SET_A
) (
    input  window_t window,
    output sum_t    sum
);

    sum_t term [NTAPS];

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam logic [2:0] TAP_IDX  = 3'(k);
        localparam logic [2:0] SLOT_IDX = 3'(NTAPS - 1 - k);
        assign term[k] = shiftAddMul(zeroExtend(window[SLOT_IDX]), coefOf(COEF_SET, TAP_IDX));
    end

    assign sum = ((term[0] + term[1]) + (term[2] + term[3]))
               + ((term[4] + term[5]) + (term[6] + term[7]));

endmodule

// File: rtl/subpel_abc_filter_simple.sv
// 8-sample sliding window feeding quarter-, half- and three-quarter-pel filters.
module subpel_abc_filter_simple
    import subpel_pkg::*;
(
    input logic                         clock,
    input logic                         reset_n,
    subpel_abc_filter_simple_if.slave   bus
);

    window_t window;

    // Slot 0 takes the newest sample; the oldest falls off slot 7.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            window <= '0;
        end else if (bus.shift_en) begin
            window <= {window[NTAPS-2:0], bus.data_in};
        end
    end

    subpel_fir8_shiftadd #(.COEF_SET(COEF_SET_A)) uFirA (
        .window (window),
        .sum    (bus.a_value)
    );

    subpel_fir8_shiftadd #(.COEF_SET(COEF_SET_B)) uFirB (
        .window (window),
        .sum    (bus.b_value)
    );

    subpel_fir8_shiftadd #(.COEF_SET(COEF_SET_C)) uFirC (
        .window (window),
        .sum    (bus.c_value)
    );

endmodule

// File: tb/tb_subpel_abc_filter_simple.sv
// Directed vector bench for the A/B/C sub-pel filter.
module tb_subpel_abc_filter_simple;
    import subpel_pkg::*;

    typedef struct {
        logic    shiftEn;
        sample_t dataIn;
        logic    check;
        sum_t    expA;
        sum_t    expB;
        sum_t    expC;
    } vec_t;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;
    vec_t vecs [$];

    subpel_abc_filter_simple_if bus ();

    subpel_abc_filter_simple dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input sum_t act, input sum_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chkAll(input string name, input sum_t ea, input sum_t eb, input sum_t ec);
        chk({name, "_a"}, bus.a_value, ea);
        chk({name, "_b"}, bus.b_value, eb);
        chk({name, "_c"}, bus.c_value, ec);
    endtask

    task automatic applyCycle(input logic en, input sample_t din);
        bus.shift_en = en;
        bus.data_in  = din;
        @(posedge clock);
        #1;
        bus.shift_en = 1'b0;
    endtask

    function automatic vec_t mk(input logic en, input sample_t din, input logic chkIt,
                                input sum_t ea, input sum_t eb, input sum_t ec);
        vec_t v;
        v.shiftEn = en;
        v.dataIn  = din;
        v.check   = chkIt;
        v.expA    = ea;
        v.expB    = eb;
        v.expC    = ec;
        return v;
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        // Impulse walking through every tap.
        vecs.push_back(mk(1'b1, 32'd1, 1'b1, 40'sd0,  40'sd0,  40'sd0));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd0,  40'sd4,  40'sd4));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, -40'sd4, -40'sd8, -40'sd8));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd16, 40'sd36, 40'sd56));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd56, 40'sd36, 40'sd16));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, -40'sd8, -40'sd8, -40'sd4));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd4,  40'sd4,  40'sd0));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd0,  40'sd0,  40'sd0));
        vecs.push_back(mk(1'b1, 32'd0, 1'b1, 40'sd0,  40'sd0,  40'sd0));
        // Constant 100.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 32'd100, i == 7, 40'sd6400, 40'sd6400, 40'sd6400));
        // Ramp: slot4=25, slot3=34 straddle the interpolation point.
        vecs.push_back(mk(1'b1, 32'd0,  1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd8,  1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd17, 1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd25, 1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd34, 1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd42, 1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd51, 1'b0, '0, '0, '0));
        vecs.push_back(mk(1'b1, 32'd59, 1'b1, 40'sd1672, 40'sd1888, 40'sd2104));
        // Hold with data_in changing.
        vecs.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b1, 40'sd1672, 40'sd1888, 40'sd2104));
        vecs.push_back(mk(1'b0, 32'h1234_5678, 1'b1, 40'sd1672, 40'sd1888, 40'sd2104));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFF, 1'b1, 40'sd1672, 40'sd1888, 40'sd2104));
        // Saturating input.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, i == 7,
                              40'sh3F_FFFF_FFC0, 40'sh3F_FFFF_FFC0, 40'sh3F_FFFF_FFC0));

        reset_n      = 1'b0;
        bus.shift_en = 1'b0;
        bus.data_in  = '0;
        #12;
        chkAll("reset", '0, '0, '0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyCycle(vecs[i].shiftEn, vecs[i].dataIn);
            if (vecs[i].check)
                chkAll($sformatf("row%0d", i), vecs[i].expA, vecs[i].expB, vecs[i].expC);
        end

        // Async reset between edges with a saturated window.
        #3;
        reset_n = 1'b0;
        #1;
        chkAll("async_rst", '0, '0, '0);
        bus.shift_en = 1'b1;
        bus.data_in  = 32'd99;
        @(posedge clock);
        #1;
        chkAll("rst_held", '0, '0, '0);
        bus.shift_en = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        applyCycle(1'b1, 32'd7);
        chkAll("post_rst_7", '0, '0, '0);
        applyCycle(1'b1, 32'd0);
        chkAll("post_rst_slot1", 40'sd0, 40'sd28, 40'sd28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
